// File: rtl/chaser_input_conditioner.sv
// Synchronises, debounces and edge-detects the chaser's DIP-switch configuration inputs.
// Define CHASER_IN_EDGE_EN to generate rise_pulse/fall_pulse/any_change; otherwise they are tied to 0.
module chaser_input_conditioner #(
    parameter int NUM_INPUTS     = 6,
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] raw_in,
    output logic [NUM_INPUTS-1:0] stable_out,
    output logic [NUM_INPUTS-1:0] rise_pulse,
    output logic [NUM_INPUTS-1:0] fall_pulse,
    output logic                  any_change,
    output logic                  settled
);

    localparam logic [DEBOUNCE_WIDTH-1:0] CNT_MAX = '1;

    logic [NUM_INPUTS-1:0] synced;
    logic [NUM_INPUTS-1:0] accept;
    logic [NUM_INPUTS-1:0] cnt_zero;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_bit
        logic [SYNC_STAGES-1:0]    chain;
        logic [DEBOUNCE_WIDTH-1:0] cnt;
        logic                      stable_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                chain <= '0;
            end else begin
                chain <= {chain[SYNC_STAGES-2:0], raw_in[i]};
            end
        end

        assign synced[i]   = chain[SYNC_STAGES-1];
        assign accept[i]   = (synced[i] != stable_q) && (cnt == CNT_MAX);
        assign cnt_zero[i] = (cnt == '0);

        // Any cycle of agreement restarts the count; MAX only returns to zero through acceptance.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt <= '0;
            end else if (synced[i] == stable_q) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DEBOUNCE_WIDTH'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                stable_q <= 1'b0;
            end else if (accept[i]) begin
                stable_q <= synced[i];
            end
        end

        assign stable_out[i] = stable_q;
    end

    assign settled = (&cnt_zero) && (synced == stable_out);

`ifdef CHASER_IN_EDGE_EN
    logic [NUM_INPUTS-1:0] rise_next;
    logic [NUM_INPUTS-1:0] fall_next;

    always_comb begin
        rise_next = accept & synced;
        fall_next = accept & ~synced;
    end

    // Registered from the same acceptance term so pulses coincide with the stable_out transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_pulse <= '0;
            fall_pulse <= '0;
            any_change <= 1'b0;
        end else begin
            rise_pulse <= rise_next;
            fall_pulse <= fall_next;
            any_change <= |(rise_next | fall_next);
        end
    end
`else
    assign rise_pulse = '0;
    assign fall_pulse = '0;
    assign any_change = 1'b0;
`endif

endmodule

// File: tb/tb_chaser_input_conditioner.sv
// Directed self-checking bench for chaser_input_conditioner (SYNC_STAGES=2, DEBOUNCE_WIDTH=3).
module tb_chaser_input_conditioner;

    localparam int N = 6;
`ifdef CHASER_IN_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] raw_in;
    logic [N-1:0] stable_out;
    logic [N-1:0] rise_pulse;
    logic [N-1:0] fall_pulse;
    logic         any_change;
    logic         settled;

    int errorCount = 0;
    int checkCount = 0;

    chaser_input_conditioner #(
        .NUM_INPUTS(N),
        .SYNC_STAGES(2),
        .DEBOUNCE_WIDTH(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw_in(raw_in),
        .stable_out(stable_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .any_change(any_change),
        .settled(settled)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [N-1:0] raw);
        reset  = rst;
        raw_in = raw;
    endtask

    task automatic stepCycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
        end
        #1;
    endtask

    function automatic logic [7:0] edgeExp(input logic [7:0] v);
        return EDGE_EN ? v : 8'h00;
    endfunction

    initial begin
        applyStimulus(1'b1, 6'h00);
        stepCycles(3);
        checkOutput("reset_stable", 8'(stable_out), 8'h00);
        checkOutput("reset_rise", 8'(rise_pulse), 8'h00);
        checkOutput("reset_fall", 8'(fall_pulse), 8'h00);
        checkOutput("reset_any", 8'(any_change), 8'h00);
        checkOutput("reset_settled", 8'(settled), 8'h01);

        applyStimulus(1'b1, 6'h3F);
        stepCycles(5);
        checkOutput("reset_hold_stable", 8'(stable_out), 8'h00);
        checkOutput("reset_hold_settled", 8'(settled), 8'h01);

        applyStimulus(1'b0, 6'h00);
        stepCycles(3);
        checkOutput("release_settled", 8'(settled), 8'h01);

        // Single-bit rise: capture edge k is the first edge after the drive, acceptance on k+9.
        applyStimulus(1'b0, 6'h01);
        stepCycles(9);
        checkOutput("b0_before_stable", 8'(stable_out), 8'h00);
        checkOutput("b0_before_rise", 8'(rise_pulse), 8'h00);
        checkOutput("b0_counting_settled", 8'(settled), 8'h00);
        stepCycles(1);
        checkOutput("b0_accept_stable", 8'(stable_out), 8'h01);
        checkOutput("b0_accept_rise", 8'(rise_pulse), edgeExp(8'h01));
        checkOutput("b0_accept_any", 8'(any_change), edgeExp(8'h01));
        stepCycles(1);
        checkOutput("b0_after_rise", 8'(rise_pulse), 8'h00);
        checkOutput("b0_after_any", 8'(any_change), 8'h00);
        checkOutput("b0_after_stable", 8'(stable_out), 8'h01);
        checkOutput("b0_after_settled", 8'(settled), 8'h01);

        // Bounce on bit 2 with 4-cycle phases never survives the 8-cycle window.
        for (int c = 0; c < 40; c++) begin
            applyStimulus(1'b0, ((c / 4) % 2 == 0) ? 6'h05 : 6'h01);
            stepCycles(1);
            checkOutput("b2_bounce_stable", 8'(stable_out), 8'h01);
            checkOutput("b2_bounce_rise", 8'(rise_pulse), 8'h00);
        end
        applyStimulus(1'b0, 6'h05);
        stepCycles(9);
        checkOutput("b2_hold_before", 8'(stable_out), 8'h01);
        stepCycles(1);
        checkOutput("b2_hold_accept", 8'(stable_out), 8'h05);
        checkOutput("b2_hold_rise", 8'(rise_pulse), edgeExp(8'h04));

        applyStimulus(1'b0, 6'h00);
        stepCycles(12);
        checkOutput("clear_stable", 8'(stable_out), 8'h00);
        checkOutput("clear_fall", 8'(fall_pulse), 8'h00);

        // Two bits accepted together.
        applyStimulus(1'b0, 6'h21);
        stepCycles(9);
        checkOutput("multi_before", 8'(stable_out), 8'h00);
        stepCycles(1);
        checkOutput("multi_stable", 8'(stable_out), 8'h21);
        checkOutput("multi_rise", 8'(rise_pulse), edgeExp(8'h21));
        checkOutput("multi_any", 8'(any_change), edgeExp(8'h01));
        stepCycles(1);
        checkOutput("multi_rise_end", 8'(rise_pulse), 8'h00);
        checkOutput("multi_any_end", 8'(any_change), 8'h00);
        applyStimulus(1'b0, 6'h00);
        stepCycles(9);
        checkOutput("multi_fall_before", 8'(stable_out), 8'h21);
        stepCycles(1);
        checkOutput("multi_fall_stable", 8'(stable_out), 8'h00);
        checkOutput("multi_fall", 8'(fall_pulse), edgeExp(8'h21));
        checkOutput("multi_fall_rise", 8'(rise_pulse), 8'h00);
        checkOutput("multi_fall_any", 8'(any_change), edgeExp(8'h01));
        stepCycles(1);
        checkOutput("multi_fall_end", 8'(fall_pulse), 8'h00);

        // Reset mid-count on bit 3 (count at 5 after edge k+6) discards progress.
        applyStimulus(1'b0, 6'h08);
        stepCycles(7);
        checkOutput("b3_midcount_stable", 8'(stable_out), 8'h00);
        applyStimulus(1'b1, 6'h08);
        stepCycles(2);
        checkOutput("b3_reset_stable", 8'(stable_out), 8'h00);
        applyStimulus(1'b0, 6'h08);
        stepCycles(3);
        checkOutput("b3_not_early", 8'(stable_out), 8'h00);
        stepCycles(6);
        checkOutput("b3_before", 8'(stable_out), 8'h00);
        stepCycles(1);
        checkOutput("b3_accept", 8'(stable_out), 8'h08);
        checkOutput("b3_rise", 8'(rise_pulse), edgeExp(8'h08));

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
